// File: rtl/m3_key_cmd_gen_pkg.sv
// Shared state encoding, key indices and timing defaults for the m3 front-panel
// command generator; shortened timings are picked up when `simulating` is defined.
package m3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FSTOP = 2'd2
    } m3_state_e;

`ifdef simulating
    localparam int unsigned DEF_DEBOUNCE_CYC = 4;
    localparam int unsigned DEF_REPEAT_DLY   = 20;
    localparam int unsigned DEF_REPEAT_PER   = 5;
`else
    localparam int unsigned DEF_DEBOUNCE_CYC = 20000;
    localparam int unsigned DEF_REPEAT_DLY   = 500000;
    localparam int unsigned DEF_REPEAT_PER   = 100000;
`endif
    localparam int unsigned DEF_CNT_W = 22;

    localparam int NUM_KEYS    = 7;
    localparam int KEY_START   = 0;
    localparam int KEY_STOP    = 1;
    localparam int KEY_DIR     = 2;
    localparam int KEY_FREQ_UP = 3;
    localparam int KEY_FREQ_DN = 4;
    localparam int KEY_PWR_UP  = 5;
    localparam int KEY_PWR_DN  = 6;

endpackage

// File: rtl/m3_key_cmd_gen_debounce.sv
// One push-button: 2-FF synchroniser, consecutive-disagreement debouncer and a
// one-cycle press event on every released->pressed flip of the debounced level.
module m3_key_debounce
    import m3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic keyN,
    output logic pressedO,
    output logic pressEvO
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Polarity is flipped at the pin so everything downstream is 1 = pressed.
    always_comb begin
        sync1_d = ~keyN;
        sync2_d = sync1_q;
        level_d = level_q;
        ev_d    = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            ev_d    = sync2_q;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            ev_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            ev_q    <= ev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressedO = level_q;
    assign pressEvO = ev_q;

endmodule

// File: rtl/m3_key_cmd_gen.sv
// Front-panel command generator: debounces seven keys, runs the start/stop/force-stop
// FSM and drives the calculator's level controls and hold-to-repeat INC/DEC pulses.
module m3_key_cmd_gen
    import m3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic keyStartN,
    input  logic keyStopN,
    input  logic keyDirN,
    input  logic keyFreqUpN,
    input  logic keyFreqDnN,
    input  logic keyPwrUpN,
    input  logic keyPwrDnN,
    output logic m3startO,
    output logic m3forceStopO,
    output logic m3invRotateO,
    output logic m3freqINCo,
    output logic m3freqDECo,
    output logic m3powerINCo,
    output logic m3powerDECo
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_lvl;
    logic [NUM_KEYS-1:0] key_ev;
    logic [1:0]          inc_w;
    logic [1:0]          dec_w;
    logic                unused_lvl;

    m3_state_e state_q;
    logic      start_q, fstop_q, inv_q, run_q;
    logic      run, run_entry;

    assign key_n = {keyPwrDnN, keyPwrUpN, keyFreqDnN, keyFreqUpN, keyDirN, keyStopN, keyStartN};
    // Start and direction act on their press events only.
    assign unused_lvl = key_lvl[KEY_START] ^ key_lvl[KEY_DIR];

    genvar gi;
    generate
        if (DEBOUNCE_CYC == 0 || REPEAT_DLY == 0 || REPEAT_PER == 0) begin : g_zero_param
            $error("m3_key_cmd_gen: timing parameters must be non-zero");
        end
        if (DEBOUNCE_CYC > CNT_MAX || REPEAT_DLY > CNT_MAX || REPEAT_PER > CNT_MAX) begin : g_cnt_w
            $error("m3_key_cmd_gen: CNT_W too narrow for timing parameters");
        end

        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            m3_key_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC),
                .CNT_W       (CNT_W)
            ) u_deb (
                .clkI    (clkI),
                .nRstI   (nRstI),
                .keyN    (key_n[gi]),
                .pressedO(key_lvl[gi]),
                .pressEvO(key_ev[gi])
            );
        end
    endgenerate

    // Stop is tested before start in every state so a simultaneous press forces a stop.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            fstop_q <= 1'b0;
            inv_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= (state_q == RUN);
            if (state_q == IDLE && key_ev[KEY_DIR])
                inv_q <= ~inv_q;
            case (state_q)
                IDLE: begin
                    if (key_ev[KEY_STOP]) begin
                        state_q <= FSTOP;
                        fstop_q <= 1'b1;
                    end else if (key_ev[KEY_START]) begin
                        state_q <= RUN;
                        start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (key_ev[KEY_STOP]) begin
                        state_q <= FSTOP;
                        start_q <= 1'b0;
                        fstop_q <= 1'b1;
                    end else if (key_ev[KEY_START]) begin
                        state_q <= IDLE;
                        start_q <= 1'b0;
                    end
                end
                FSTOP: begin
                    if (!key_lvl[KEY_STOP]) begin
                        state_q <= IDLE;
                        fstop_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                    fstop_q <= 1'b0;
                end
            endcase
        end
    end

    assign run       = (state_q == RUN);
    assign run_entry = run & ~run_q;

    // Repeat engines: index 0 = frequency pair, 1 = power pair.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rep
            localparam int UP_IDX = KEY_FREQ_UP + 2 * gi;
            localparam int DN_IDX = UP_IDX + 1;

            logic             up, dn, held, both, fire;
            logic             active_q, active_d;
            logic             rep_q, rep_d;
            logic             both_q;
            logic             inc_q, inc_d, dec_q, dec_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                up       = key_lvl[UP_IDX];
                dn       = key_lvl[DN_IDX];
                held     = up ^ dn;
                both     = up & dn;
                fire     = 1'b0;
                active_d = active_q;
                rep_d    = rep_q;
                cnt_d    = cnt_q;
                if (!run || !held) begin
                    active_d = 1'b0;
                    rep_d    = 1'b0;
                    cnt_d    = '0;
                end else if (!active_q) begin
                    // A fresh hold starts on a press, a conflict clearing, or RUN entry.
                    if (key_ev[UP_IDX] || key_ev[DN_IDX] || both_q || run_entry) begin
                        fire     = 1'b1;
                        active_d = 1'b1;
                        cnt_d    = '0;
                    end
                end else if (cnt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
                    fire  = 1'b1;
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                inc_d = fire & up;
                dec_d = fire & dn;
            end

            always_ff @(posedge clkI or negedge nRstI) begin
                if (!nRstI) begin
                    active_q <= 1'b0;
                    rep_q    <= 1'b0;
                    both_q   <= 1'b0;
                    inc_q    <= 1'b0;
                    dec_q    <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    active_q <= active_d;
                    rep_q    <= rep_d;
                    both_q   <= both;
                    inc_q    <= inc_d;
                    dec_q    <= dec_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign inc_w[gi] = inc_q;
            assign dec_w[gi] = dec_q;
        end
    endgenerate

    assign m3startO     = start_q;
    assign m3forceStopO = fstop_q;
    assign m3invRotateO = inv_q;
    assign m3freqINCo   = inc_w[0];
    assign m3freqDECo   = dec_w[0];
    assign m3powerINCo  = inc_w[1];
    assign m3powerDECo  = dec_w[1];

endmodule

// File: tb/tb_m3_key_cmd_gen.sv
// Directed bench for m3_key_cmd_gen with DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5;
// inputs change 1 time unit after a rising edge and outputs are checked there too.
module tb_m3_key_cmd_gen;

    logic clkI = 1'b0;
    logic nRstI = 1'b1;
    logic keyStartN = 1'b1, keyStopN = 1'b1, keyDirN = 1'b1;
    logic keyFreqUpN = 1'b1, keyFreqDnN = 1'b1, keyPwrUpN = 1'b1, keyPwrDnN = 1'b1;
    logic m3startO, m3forceStopO, m3invRotateO;
    logic m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clkI = ~clkI;

    m3_key_cmd_gen #(
        .DEBOUNCE_CYC(4),
        .REPEAT_DLY  (20),
        .REPEAT_PER  (5),
        .CNT_W       (22)
    ) dut (
        .clkI        (clkI),
        .nRstI       (nRstI),
        .keyStartN   (keyStartN),
        .keyStopN    (keyStopN),
        .keyDirN     (keyDirN),
        .keyFreqUpN  (keyFreqUpN),
        .keyFreqDnN  (keyFreqDnN),
        .keyPwrUpN   (keyPwrUpN),
        .keyPwrDnN   (keyPwrDnN),
        .m3startO    (m3startO),
        .m3forceStopO(m3forceStopO),
        .m3invRotateO(m3invRotateO),
        .m3freqINCo  (m3freqINCo),
        .m3freqDECo  (m3freqDECo),
        .m3powerINCo (m3powerINCo),
        .m3powerDECo (m3powerDECo)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clkI);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_lvl(input string tag, input logic st, input logic fs, input logic inv);
        chk({tag, ".start"}, m3startO, st);
        chk({tag, ".fstop"}, m3forceStopO, fs);
        chk({tag, ".inv"}, m3invRotateO, inv);
    endtask

    initial begin
        logic exp_a, exp_b, exp_s;

        // Reset
        #2 nRstI = 1'b0;
        tick(3);
        chk_lvl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.fINC", m3freqINCo, 1'b0);
        chk("reset.fDEC", m3freqDECo, 1'b0);
        chk("reset.pINC", m3powerINCo, 1'b0);
        chk("reset.pDEC", m3powerDECo, 1'b0);
        nRstI = 1'b1;
        tick(2);
        chk_lvl("post_reset", 1'b0, 1'b0, 1'b0);
        $display("step: reset released, outputs idle");

        // Start press: visible exactly 7 clk after the raw fall
        keyStartN = 1'b0;
        tick(6);
        chk("start_t6", m3startO, 1'b0);
        tick(1);
        chk_lvl("start_t7", 1'b1, 1'b0, 1'b0);
        tick(3);
        keyStartN = 1'b1;
        tick(10);
        chk("start_release", m3startO, 1'b1);
        $display("step: start press -> RUN");

        // 3-clk glitch on start must not toggle RUN
        keyStartN = 1'b0;
        tick(3);
        keyStartN = 1'b1;
        tick(12);
        chk("glitch", m3startO, 1'b1);
        $display("step: start glitch ignored");

        // Force stop from RUN, then release back to IDLE
        keyStopN = 1'b0;
        tick(6);
        chk_lvl("stop_t6", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_lvl("stop_t7", 1'b0, 1'b1, 1'b0);
        tick(23);
        chk("stop_hold", m3forceStopO, 1'b1);
        keyStopN = 1'b1;
        tick(6);
        chk("stoprel_t6", m3forceStopO, 1'b1);
        tick(1);
        chk_lvl("stoprel_t7", 1'b0, 1'b0, 1'b0);
        tick(5);
        $display("step: force stop and release");

        // Simultaneous start and stop in IDLE: stop wins
        keyStartN = 1'b0;
        keyStopN  = 1'b0;
        tick(7);
        chk_lvl("both_t7", 1'b0, 1'b1, 1'b0);
        tick(3);
        keyStartN = 1'b1;
        keyStopN  = 1'b1;
        tick(7);
        chk_lvl("both_rel", 1'b0, 1'b0, 1'b0);
        tick(5);
        $display("step: start+stop same cycle -> FSTOP");

        // Direction toggles in IDLE
        keyDirN = 1'b0;
        tick(6);
        chk("dir_t6", m3invRotateO, 1'b0);
        tick(1);
        chk("dir_t7", m3invRotateO, 1'b1);
        tick(3);
        keyDirN = 1'b1;
        tick(10);
        $display("step: dir in IDLE -> invRotate 1");

        // Enter RUN, direction press ignored
        keyStartN = 1'b0;
        tick(7);
        chk_lvl("run2", 1'b1, 1'b0, 1'b1);
        tick(3);
        keyStartN = 1'b1;
        tick(10);
        keyDirN = 1'b0;
        tick(10);
        chk("dir_run", m3invRotateO, 1'b1);
        keyDirN = 1'b1;
        tick(10);
        chk("dir_run_rel", m3invRotateO, 1'b1);
        $display("step: dir in RUN ignored");

        // Auto-repeat on freqUp: pulses at 7, 27, 32, ... while the level is held (to 66)
        keyFreqUpN = 1'b0;
        for (int t = 1; t <= 75; t++) begin
            tick(1);
            exp_a = (t == 7) || (t >= 27 && t <= 66 && (t - 27) % 5 == 0);
            chk($sformatf("fINC@%0d", t), m3freqINCo, exp_a);
            chk($sformatf("fDEC@%0d", t), m3freqDECo, 1'b0);
            if (t == 60) keyFreqUpN = 1'b1;
        end
        tick(5);
        $display("step: freqUp auto-repeat");

        // Power conflict: up held, down added, up released -> DEC resumes
        keyPwrUpN = 1'b0;
        for (int t = 1; t <= 90; t++) begin
            tick(1);
            exp_a = (t == 7);
            exp_b = (t == 47) || (t >= 67 && t <= 86 && (t - 67) % 5 == 0);
            chk($sformatf("pINC@%0d", t), m3powerINCo, exp_a);
            chk($sformatf("pDEC@%0d", t), m3powerDECo, exp_b);
            if (t == 10) keyPwrDnN = 1'b0;
            if (t == 40) keyPwrUpN = 1'b1;
            if (t == 80) keyPwrDnN = 1'b1;
        end
        tick(5);
        $display("step: power up/down conflict");

        // Leave RUN with freqDn held, then re-enter RUN
        keyFreqDnN = 1'b0;
        for (int t = 1; t <= 80; t++) begin
            tick(1);
            exp_b = (t == 7) || (t == 48) || (t >= 68 && t <= 76 && (t - 68) % 5 == 0);
            exp_s = (t < 17) || (t >= 47);
            chk($sformatf("fDEC2@%0d", t), m3freqDECo, exp_b);
            chk($sformatf("fINC2@%0d", t), m3freqINCo, 1'b0);
            chk($sformatf("start2@%0d", t), m3startO, exp_s);
            if (t == 10) keyStartN = 1'b0;
            if (t == 16) keyStartN = 1'b1;
            if (t == 40) keyStartN = 1'b0;
            if (t == 46) keyStartN = 1'b1;
            if (t == 70) keyFreqDnN = 1'b1;
        end
        tick(5);
        $display("step: leave and re-enter RUN with freqDn held");

        // Back to IDLE, direction toggles back to 0
        keyStartN = 1'b0;
        tick(7);
        chk("idle3", m3startO, 1'b0);
        tick(3);
        keyStartN = 1'b1;
        tick(10);
        keyDirN = 1'b0;
        tick(6);
        chk("dir2_t6", m3invRotateO, 1'b1);
        tick(1);
        chk("dir2_t7", m3invRotateO, 1'b0);
        tick(3);
        keyDirN = 1'b1;
        tick(10);
        $display("step: dir in IDLE -> invRotate 0");

        // Reset mid-RUN with start still held: key must be re-debounced
        keyStartN = 1'b0;
        tick(7);
        chk("run4", m3startO, 1'b1);
        tick(2);
        nRstI = 1'b0;
        #1;
        chk_lvl("midreset", 1'b0, 1'b0, 1'b0);
        tick(3);
        nRstI = 1'b1;
        tick(6);
        chk("redeb_t6", m3startO, 1'b0);
        tick(1);
        chk("redeb_t7", m3startO, 1'b1);
        keyStartN = 1'b1;
        tick(10);
        $display("step: reset mid-operation and re-debounce");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/m3_key_cmd_gen.md
Name: m3_key_cmd_gen

Overview:
Front-panel command generator that drives the m3 power/speed calculator's control inputs.
- Synchronises and debounces seven raw active-low push-buttons.
- Runs a start/stop/force-stop state machine.
- Produces the level controls (start, forceStop, invRotate) and single-cycle INC/DEC pulses with hold-to-repeat.
- Sits between the board pins and the power/speed calculator, on the same 1 MHz clock domain.

Parameters:
DEBOUNCE_CYC, 20000, cycles a synced key must differ from its debounced level before the level flips (20 ms @1 MHz).
REPEAT_DLY, 500000, cycles a key is held after its first pulse before auto-repeat starts.
REPEAT_PER, 100000, cycles between auto-repeat pulses.
CNT_W, 22, counter width; must hold max(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER).

Ports:
clkI  input  1  clock, 1 MHz
nRstI  input  1  reset, asynchronous, active-low
keyStartN  input  1  raw start/stop toggle button, active-low, asynchronous
keyStopN  input  1  raw emergency-stop button, active-low
keyDirN  input  1  raw direction toggle button, active-low
keyFreqUpN  input  1  raw frequency-up button, active-low
keyFreqDnN  input  1  raw frequency-down button, active-low
keyPwrUpN  input  1  raw power-up button, active-low
keyPwrDnN  input  1  raw power-down button, active-low
m3startO  output  1  run level to calculator
m3forceStopO  output  1  force-stop level
m3invRotateO  output  1  direction level
m3freqINCo  output  1  one-cycle pulse
m3freqDECo  output  1  one-cycle pulse
m3powerINCo  output  1  one-cycle pulse
m3powerDECo  output  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all debounced levels = released, all counters 0.
- Per key: 2-FF synchroniser, then a debouncer.
  - Counter counts consecutive cycles with synced != level. Any agreement clears the counter.
  - When the count reaches DEBOUNCE_CYC the level flips and the counter clears.
  - pressEv = one-cycle pulse on a released->pressed flip.
- Latency: raw stable edge to pressEv = DEBOUNCE_CYC+2 clk. Registered outputs follow pressEv by 1 clk, so total is DEBOUNCE_CYC+3.
- Glitches shorter than DEBOUNCE_CYC produce no event.
- FSM states and transitions:
  - IDLE (start=0, forceStop=0): startEv -> RUN; stopEv -> FSTOP.
  - RUN (start=1): stopEv -> FSTOP; startEv -> IDLE.
  - FSTOP (start=0, forceStop=1): stays while stop level pressed; stop released -> IDLE. startEv is ignored in FSTOP.
  - Same-cycle stopEv and startEv: stop wins.
- Direction: dirEv toggles m3invRotateO only in IDLE. dirEv is ignored in RUN and FSTOP; the level holds.
- Repeat engines: two independent engines, one for the freq pair and one for the power pair, identical logic.
  - Active only in RUN. Leaving RUN clears both engines and suppresses pulses.
  - Held key = exactly one of the pair's up/down levels pressed.
  - Both held: no pulses, engine cleared. Neither held: engine cleared.
  - First pulse on the pressEv of the held key, or in the cycle the pair goes from both-held to exactly one held.
  - Then a pulse every REPEAT_DLY cycles after the first pulse, then every REPEAT_PER cycles after that, while held.
  - Release clears the engine; no pulse is emitted on release.
  - Entering RUN while a key is already held: the first pulse comes on the cycle after the RUN entry, then repeat timing applies.
- Pulses are exactly 1 clk wide. INC and DEC of the same pair are never both high.
- Counters saturate and never wrap. Parameter values of 0 are illegal and the elaboration check fails.
- Reset mid-operation: immediate return to reset values. Held keys must be re-debounced after reset.

Decomposition:
- Shared package m3_pkg:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, FSTOP=2'd2.
  - Default timing constants for DEBOUNCE_CYC/REPEAT_DLY/REPEAT_PER.
  - Simulation-shortened values selected by the `simulating` define.
- Sub-module m3_key_debounce (sync + debounce + pressEv), instantiated 7 times.
- The repeat engine is a generate/function block inside the top module; it is not a separate module.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5):
- Reset check: keys released, nRstI pulsed -> all outputs 0. Press start 10 clk -> m3startO=1 exactly 7 clk after raw fall. A 3-clk glitch on start -> no change.
- Force stop: in RUN, press stop -> m3startO=0, m3forceStopO=1 after 7 clk. Hold 30 clk, release -> forceStop=0 7 clk after release, FSM IDLE. Start+stop edges in the same cycle -> FSTOP.
- Direction: dir press in IDLE -> invRotate 0->1. In RUN -> stays 1. Back in IDLE, press -> 0.
- Auto-repeat: RUN, hold freqUp 60 clk -> first pulse at t=7, then at 27, 32, 37, … until release, each 1 clk wide. freqDECo stays 0.
- Conflict: RUN, hold pwrUp then add pwrDn -> pulses stop. Release pwrUp -> a single pwrDEC pulse in the next cycle, then repeat from that point.
- Leave RUN while freqDn is held -> no further pulses. Re-enter RUN with freqDn still held -> a pulse on the cycle after the RUN entry.
